alu_issue: RTL

Multicycle issue/writeback sequencer that drives the datapath ALU and consumes its result and NZCV flags. It accepts one data-processing instruction with its two register operands over a valid/ready handshake, decodes the instruction to the ALU control code, and evaluates the condition field against a held NZCV register. It then updates the flags and presents a writeback to the register file.

---
 rtl/alu_pkg.sv | 77 +++++++
 rtl/cond_check.sv | 39 +++
 rtl/alu_issue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared codes, state encoding and decode helper for alu_issue
package alu_pkg;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_CMN = 4'b1011;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;
  localparam logic [3:0] CMD_MVN = 4'b1111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] ctrl;
    logic       is_cmp;
    logic       is_arith;
  } dec_t;

  // Compare/test ops reuse the ALU function of their arithmetic or logical twin.
  function automatic dec_t decode(input logic [1:0] op, input logic [3:0] cmd);
    dec_t d;
    d = '0;
    if (op == 2'b00) begin
      d.legal = 1'b1;
      case (cmd)
        CMD_AND: d.ctrl = ALU_AND;
        CMD_SUB: begin d.ctrl = ALU_SUB; d.is_arith = 1'b1; end
        CMD_ADD: begin d.ctrl = ALU_ADD; d.is_arith = 1'b1; end
        CMD_ORR: d.ctrl = ALU_ORR;
        CMD_MOV: d.ctrl = ALU_MOV;
        CMD_MVN: d.ctrl = ALU_MVN;
        CMD_TST: begin d.ctrl = ALU_AND; d.is_cmp = 1'b1; end
        CMD_CMP: begin d.ctrl = ALU_SUB; d.is_cmp = 1'b1; d.is_arith = 1'b1; end
        CMD_CMN: begin d.ctrl = ALU_ADD; d.is_cmp = 1'b1; d.is_arith = 1'b1; end
        default: d = '0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational condition-field evaluation against NZCV
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - three-cycle issue/writeback sequencer around the datapath ALU
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        illegal,
  output logic [3:0]  flags_q
);

  state_t      state_q, state_d;
  dec_t        dec;
  logic        accept;
  logic        cond_pass;
  logic [31:0] imm_ext;
  logic [4:0]  rot;
  logic [31:0] imm_rot;
  logic [31:0] operand2;
  logic [3:0]  cond_q, rd_q;
  logic        s_q, cmp_q, arith_q;
  logic [3:0]  next_flags;
  logic [3:0]  unused_rn;

  assign unused_rn = instr[19:16];

  assign dec         = decode(instr[27:26], instr[24:21]);
  assign instr_ready = (state_q == ST_IDLE);
  assign accept      = instr_valid && instr_ready;

  // Rotate via a doubled copy so a zero rotate amount needs no special case.
  assign imm_ext  = {24'b0, instr[7:0]};
  assign rot      = {instr[11:8], 1'b0};
  assign imm_rot  = 32'({imm_ext, imm_ext} >> rot);
  assign operand2 = instr[25] ? imm_rot : op_b;

  cond_check u_cond_check (
    .cond  (cond_q),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  // Logical ops only own N and Z; C and V stay architectural.
  assign next_flags = arith_q ? alu_flags
                              : {alu_flags[FLAG_N], alu_flags[FLAG_Z], flags_q[FLAG_C], flags_q[FLAG_V]};

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = dec.legal ? ST_EXEC : ST_WB;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      cond_q      <= '0;
      rd_q        <= '0;
      s_q         <= 1'b0;
      cmp_q       <= 1'b0;
      arith_q     <= 1'b0;
      wb_valid    <= 1'b0;
      wb_we       <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      illegal     <= 1'b0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            alu_a  <= op_a;
            alu_b  <= operand2;
            cond_q <= instr[31:28];
            rd_q   <= instr[15:12];
            s_q    <= instr[20];
            if (dec.legal) begin
              alu_control <= dec.ctrl;
              cmp_q       <= dec.is_cmp;
              arith_q     <= dec.is_arith;
            end else begin
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              illegal  <= 1'b1;
              wb_rd    <= instr[15:12];
            end
          end
        end
        ST_EXEC: begin
          wb_valid <= 1'b1;
          wb_rd    <= rd_q;
          wb_data  <= alu_result;
          wb_we    <= cond_pass && !cmp_q;
          if (cond_pass && (s_q || cmp_q)) flags_q <= next_flags;
        end
        ST_WB: begin
          wb_valid <= 1'b0;
          wb_we    <= 1'b0;
          illegal  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
